hex_display_scanner: RTL

- Time-multiplexes one shared 7-segment hex decoder across NUM_DIGITS common-anode digits.
- Each cycle it presents one nibble to the decoder and drives the matching active-low digit select. A dead-time interval between digits prevents ghosting.
- New display values are taken through a valid/ready load port into a shadow register. They are committed only at frame boundaries, so a frame never shows torn data.

---
 rtl/hex_display_scanner.sv | 117 +++++++++++
 1 files changed

// File: rtl/hex_display_scanner.sv
// Time-multiplexed hex digit scanner: one shared decoder, dead-time blanking, frame-synchronous load.
// Optional leading-zero suppression is enabled with `define LEADING_ZERO_BLANK_EN.
module hex_display_scanner #(
    parameter int NUM_DIGITS   = 4,
    parameter int DWELL_CYCLES = 50000,
    parameter int DEAD_CYCLES  = 500
) (
    input  logic                    clock,
    input  logic                    resetn,
    input  logic                    load_valid,
    input  logic [4*NUM_DIGITS-1:0] load_data,
    output logic                    load_ready,
    input  logic [NUM_DIGITS-1:0]   blank_mask,
    output logic [3:0]              hex_nibble,
    output logic                    seg_blank,
    output logic [NUM_DIGITS-1:0]   digit_sel_n,
    output logic                    frame_tick
);
    localparam int CW = $clog2(DWELL_CYCLES);
    localparam int IW = $clog2(NUM_DIGITS);
    localparam logic [CW-1:0] DEAD_LAST = CW'(DEAD_CYCLES - 1);
    localparam logic [CW-1:0] SLOT_LAST = CW'(DWELL_CYCLES - 1);
    localparam logic [IW-1:0] IDX_LAST  = IW'(NUM_DIGITS - 1);

    typedef enum logic {DEAD = 1'b0, DRIVE = 1'b1} state_t;

    state_t                     state, state_nx;
    logic [CW-1:0]              cnt;
    logic [IW-1:0]              idx;
    logic [NUM_DIGITS-1:0][3:0] shadow, active;
    logic                       pending;
    logic                       boundary;
    logic                       slot_end, frame_end, suppress, accept;
    logic [NUM_DIGITS-1:0]      sel_nx;
    logic                       blank_nx;
    logic [3:0]                 nib_nx;

    assign slot_end  = (cnt == SLOT_LAST);
    assign frame_end = slot_end && (idx == IDX_LAST);
    // load_ready lags pending by a cycle, so pending also gates acceptance
    assign accept    = load_valid && load_ready && !pending;

`ifdef LEADING_ZERO_BLANK_EN
    // lz[i]: digit i and every digit above it are zero
    logic [NUM_DIGITS-1:0] lz;
    assign lz[NUM_DIGITS-1] = (active[NUM_DIGITS-1] == 4'h0);
    for (genvar i = 0; i < NUM_DIGITS-1; i++) begin : g_lz
        assign lz[i] = lz[i+1] && (active[i] == 4'h0);
    end
    assign suppress = (idx != '0) && lz[idx];
`else
    assign suppress = 1'b0;
`endif

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state <= DEAD;
            cnt   <= '0;
            idx   <= '0;
        end else begin
            state <= state_nx;
            cnt   <= slot_end ? '0 : cnt + CW'(1);
            if (slot_end)
                idx <= (idx == IDX_LAST) ? '0 : idx + IW'(1);
        end
    end

    always_comb begin
        state_nx = state;
        case (state)
            DEAD:    if (cnt == DEAD_LAST) state_nx = DRIVE;
            DRIVE:   if (slot_end)         state_nx = DEAD;
            default: state_nx = DEAD;
        endcase
    end

    always_comb begin
        sel_nx   = '1;
        blank_nx = 1'b1;
        nib_nx   = hex_nibble;
        if (state == DRIVE) begin
            nib_nx   = active[idx];
            blank_nx = blank_mask[idx] | suppress;
            if (!suppress)
                sel_nx[idx] = 1'b0;
        end
    end

    // boundary marks the wrap edge; tick and commit land one edge later, in the new frame's first DEAD cycle
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            digit_sel_n <= '1;
            hex_nibble  <= 4'h0;
            seg_blank   <= 1'b1;
            load_ready  <= 1'b1;
            frame_tick  <= 1'b0;
            boundary    <= 1'b0;
            shadow      <= '0;
            active      <= '0;
            pending     <= 1'b0;
        end else begin
            digit_sel_n <= sel_nx;
            hex_nibble  <= nib_nx;
            seg_blank   <= blank_nx;
            load_ready  <= ~pending;
            boundary    <= frame_end;
            frame_tick  <= boundary;
            if (boundary && pending) begin
                active  <= shadow;
                pending <= 1'b0;
            end else if (accept) begin
                shadow  <= load_data;
                pending <= 1'b1;
            end
        end
    end
endmodule
